// File: rtl/floor_scroller.sv
// floor_scroller: scrolls N_FLOORS platforms upward once per frame, updating
// one floor per clock. Floors that leave the top respawn at the bottom with
// an LFSR-derived x position and spike flag.
module floor_scroller #(
  parameter int          N_FLOORS  = 5,
  parameter int          Y_MIN     = 0,
  parameter int          Y_MAX     = 479,
  parameter int          FLOOR_W   = 90,
  parameter int          FLOOR_H   = 20,
  parameter int          X_SPAN    = 640,
  parameter int          Y_INIT0   = 30,
  parameter int          Y_GAP     = 100,
  parameter int          X_INIT0   = 60,
  parameter int          X_STRIDE  = 40,
  parameter int          STEP_BASE = 1,
  parameter int          STEP_MAX  = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_clk,
  input  logic                    pause,
  input  logic [3:0]              score1,
  input  logic [3:0]              score0,
  output logic [N_FLOORS*10-1:0]  floor_x,
  output logic [N_FLOORS*10-1:0]  floor_y,
  output logic [N_FLOORS-1:0]     floor_spike,
  output logic [2:0]              step_out,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int          X_RANGE = X_SPAN - FLOOR_W;
  localparam logic [15:0] TAPS    = 16'hB400;

  function automatic logic [N_FLOORS*10-1:0] init_vec(input int base, input int stride);
    logic [N_FLOORS*10-1:0] v;
    v = '0;
    for (int i = 0; i < N_FLOORS; i++) v[i*10 +: 10] = 10'(base + i * stride);
    return v;
  endfunction

  localparam logic [N_FLOORS*10-1:0] X_INIT_V = init_vec(X_INIT0, X_STRIDE);
  localparam logic [N_FLOORS*10-1:0] Y_INIT_V = init_vec(Y_INIT0, Y_GAP);

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [2:0]              step_q, step_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [N_FLOORS*10-1:0]  x_q, x_d;
  logic [N_FLOORS*10-1:0]  y_q, y_d;
  logic [N_FLOORS-1:0]     sp_q, sp_d;
  logic                    frame_q;

  logic                    frame_rise;
  logic [4:0]              step_sum;
  logic [2:0]              step_calc;
  logic [9:0]              cur_y;
  logic                    respawn;
  logic [15:0]             lfsr_nxt;
  logic [9:0]              x_new;
  logic                    score0_unused;

  // score0 does not influence scrolling speed; only the tens digit does
  assign score0_unused = ^score0;

  assign frame_rise = frame_clk & ~frame_q;

  // Step from score tens digit, clamped; per-floor respawn arithmetic
  always_comb begin
    step_sum  = 5'(STEP_BASE) + {1'b0, score1};
    step_calc = (step_sum > 5'(STEP_MAX)) ? 3'(STEP_MAX) : step_sum[2:0];
    cur_y     = y_q[int'(idx_q)*10 +: 10];
    respawn   = ({1'b0, cur_y} < (11'(Y_MIN) + 11'(step_q)));
    lfsr_nxt  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    x_new     = lfsr_nxt[9:0];
    if (x_new >= 10'(X_RANGE)) x_new = x_new - 10'(X_RANGE);
  end

  // FSM next-state, serial floor update and status outputs
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    step_d     = step_q;
    lfsr_d     = lfsr_q;
    x_d        = x_q;
    y_d        = y_q;
    sp_d       = sp_q;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_rise && !pause) begin
          step_d  = step_calc;
          idx_d   = '0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        busy = 1'b1;
        if (respawn) begin
          y_d[int'(idx_q)*10 +: 10] = 10'(Y_MAX - FLOOR_H);
          x_d[int'(idx_q)*10 +: 10] = x_new;
          sp_d[idx_q]               = lfsr_nxt[15] & lfsr_nxt[14];
          lfsr_d                    = lfsr_nxt;
        end else begin
          y_d[int'(idx_q)*10 +: 10] = cur_y - 10'(step_q);
        end
        if (idx_q == 4'(N_FLOORS - 1)) state_d = DONE;
        else                           idx_d   = idx_q + 4'd1;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and floor registers; reset restores the initial floor layout
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      step_q  <= 3'(STEP_BASE);
      lfsr_q  <= LFSR_SEED;
      x_q     <= X_INIT_V;
      y_q     <= Y_INIT_V;
      sp_q    <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      lfsr_q  <= lfsr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sp_q    <= sp_d;
      frame_q <= frame_clk;
    end
  end

  assign floor_x     = x_q;
  assign floor_y     = y_q;
  assign floor_spike = sp_q;
  assign step_out    = step_q;

endmodule

// File: tb/tb_floor_scroller.sv
// Testbench for floor_scroller: random frames against a behavioural model,
// scoreboard checked on each frame_done pulse.
module tb_floor_scroller;
  localparam int N = 5;

  logic            Clk = 1'b0;
  logic            Reset = 1'b0;
  logic            frame_clk = 1'b0;
  logic            pause = 1'b0;
  logic [3:0]      score1 = 4'd0;
  logic [3:0]      score0 = 4'd0;
  logic [N*10-1:0] floor_x, floor_y;
  logic [N-1:0]    floor_spike;
  logic [2:0]      step_out;
  logic            busy, frame_done;

  floor_scroller dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .pause(pause),
    .score1(score1), .score0(score0),
    .floor_x(floor_x), .floor_y(floor_y), .floor_spike(floor_spike),
    .step_out(step_out), .busy(busy), .frame_done(frame_done)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;

  // behavioural model state
  int my[N];
  int mx[N];
  int msp[N];
  int mstep;
  int lfsr;

  typedef struct packed {
    logic [N*10-1:0] x;
    logic [N*10-1:0] y;
    logic [N-1:0]    sp;
    logic [2:0]      st;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      my[i]  = 30 + 100 * i;
      mx[i]  = 60 + 40 * i;
      msp[i] = 0;
    end
    mstep = 1;
    lfsr  = 'hACE1;
  endtask

  task automatic model_frame(input int s1);
    mstep = (1 + s1 > 4) ? 4 : 1 + s1;
    for (int i = 0; i < N; i++) begin
      if (my[i] < mstep) begin
        my[i] = 459;
        lfsr  = (lfsr >> 1) ^ (((lfsr & 1) != 0) ? 'hB400 : 0);
        mx[i] = lfsr & 1023;
        if (mx[i] >= 550) mx[i] = mx[i] - 550;
        msp[i] = (((lfsr >> 15) & 1) == 1 && ((lfsr >> 14) & 1) == 1) ? 1 : 0;
      end else begin
        my[i] = my[i] - mstep;
      end
    end
  endtask

  function automatic exp_t model_pack();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.x[i*10 +: 10] = 10'(mx[i]);
      e.y[i*10 +: 10] = 10'(my[i]);
      e.sp[i]         = msp[i][0];
    end
    e.st = 3'(mstep);
    return e;
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_x%0d", tag, i), int'(floor_x[i*10 +: 10]), mx[i]);
      chk($sformatf("%s_y%0d", tag, i), int'(floor_y[i*10 +: 10]), my[i]);
      chk($sformatf("%s_sp%0d", tag, i), int'(floor_spike[i]), msp[i]);
    end
    chk($sformatf("%s_step", tag), int'(step_out), mstep);
    chk($sformatf("%s_busy", tag), int'(busy), 0);
  endtask

  // Monitor: every frame_done must match the oldest outstanding frame
  always @(negedge Clk) begin
    if (Reset === 1'b1 && frame_done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_frame_done: got pulse expected none");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        for (int i = 0; i < N; i++) begin
          chk($sformatf("sb_x%0d", i), int'(floor_x[i*10 +: 10]), int'(e.x[i*10 +: 10]));
          chk($sformatf("sb_y%0d", i), int'(floor_y[i*10 +: 10]), int'(e.y[i*10 +: 10]));
          chk($sformatf("sb_sp%0d", i), int'(floor_spike[i]), int'(e.sp[i]));
        end
        chk("sb_step", int'(step_out), int'(e.st));
      end
    end
  end

  // One accepted frame; a second rise during the pass must be ignored
  task automatic frame_go(input bit timing, input bit chg_score);
    model_frame(int'(score1));
    sbq.push_back(model_pack());
    @(posedge Clk); #1 frame_clk = 1'b1;
    for (int c = 1; c <= N + 4; c++) begin
      @(posedge Clk); #2;
      if (timing) begin
        chk($sformatf("busy_c%0d", c), int'(busy), (c <= N) ? 1 : 0);
        chk($sformatf("done_c%0d", c), int'(frame_done), (c == N + 1) ? 1 : 0);
      end
      if (c == 1) begin
        frame_clk = 1'b0;
        if (chg_score) score1 = 4'($urandom_range(0, 9));
      end
      if (c == 3) frame_clk = 1'b1;
    end
    frame_clk = 1'b0;
  endtask

  // A frame edge while paused: nothing may move
  task automatic frame_paused();
    pause = 1'b1;
    @(posedge Clk); #1 frame_clk = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge Clk); #2;
      chk("pause_busy", int'(busy), 0);
    end
    frame_clk = 1'b0;
    @(posedge Clk); #1 pause = 1'b0;
  endtask

  task automatic do_reset();
    #1 Reset = 1'b0;
    #1 model_reset();
    sbq.delete();
    check_all("rst");
    chk("rst_done", int'(frame_done), 0);
    @(posedge Clk); @(posedge Clk); #1 Reset = 1'b1;
  endtask

  initial begin
    model_reset();
    // power-on reset
    repeat (2) @(posedge Clk);
    #1 check_all("por");
    Reset = 1'b1;

    // step 1 frames: floor 0 reaches 0 after 30 frames, respawns on 31
    score1 = 4'd0;
    score0 = 4'd0;
    for (int f = 0; f < 30; f++) frame_go(f == 0, 1'b0);
    chk("y0_after30", int'(floor_y[9:0]), 0);
    frame_go(1'b0, 1'b0);
    chk("y0_respawn", int'(floor_y[9:0]), 459);
    chk("x0_respawn", int'(floor_x[9:0]), 74);
    chk("sp0_respawn", int'(floor_spike[0]), 1);

    // mid-sim reset, then y=2 with step 3 must respawn
    @(posedge Clk); do_reset();
    for (int f = 0; f < 28; f++) frame_go(1'b0, 1'b0);
    chk("y0_is2", int'(floor_y[9:0]), 2);
    score1 = 4'd2;
    frame_go(1'b1, 1'b0);
    chk("step3", int'(step_out), 3);
    chk("y0_step3_respawn", int'(floor_y[9:0]), 459);
    chk("y1_step3", int'(floor_y[19:10]), 99);
    score1 = 4'd9;
    frame_go(1'b0, 1'b0);
    chk("step_clamp", int'(step_out), 4);

    // fresh reset, step 3 single frame
    @(posedge Clk); do_reset();
    score1 = 4'd2;
    frame_go(1'b0, 1'b1);
    chk("y1_127", int'(floor_y[19:10]), 127);

    // pause holds everything
    for (int f = 0; f < 10; f++) frame_paused();
    check_all("paused");
    score1 = 4'd1;
    frame_go(1'b1, 1'b0);

    // reset in cycle T+3 of a pass
    @(posedge Clk); #1 frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    frame_clk = 1'b0;
    do_reset();
    repeat (10) @(posedge Clk);
    #1 check_all("post_abort");
    score1 = 4'd0;
    frame_go(1'b1, 1'b0);

    // randomized frames, pauses and mid-pass score changes
    for (int k = 0; k < 40; k++) begin
      score1 = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) begin
        frame_paused();
        check_all("rnd_pause");
      end else begin
        frame_go(1'b1, 1'($urandom_range(0, 1)));
      end
    end

    repeat (4) @(posedge Clk);
    #1 chk("sb_empty", sbq.size(), 0);
    check_all("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
